// File: rtl/vend_ctrl_param_if.sv
// vend_ctrl_param_if
//   Groups the front-end and dispenser/hopper signals of the vending
//   controller into one bundle.
//   master : drives coins, selections, the return button and refills, and
//            observes the controller outputs (front end / testbench side).
//   slave  : the controller itself.
//   Signals:
//     i_input_coin      coin-inserted pulses, one bit per denomination
//     i_select_item     item selection pulses
//     i_trigger_return  return button level
//     i_refill          per-item refill pulses
//     o_available_item  items purchasable with the current total
//     o_sold_out        items with zero stock
//     o_output_item     one-hot dispense pulse
//     o_return_coin     one-hot change pulse
//     o_coin_reject     coin dropped because the total would overflow
//     o_coin_total      current credit
//     o_state           controller state (IDLE/COIN/DISPENSE/RETURN)
interface vend_ctrl_param_if #(
  parameter int NUM_ITEMS = 4,
  parameter int NUM_COINS = 3,
  parameter int TOTAL_W   = 32
);
  logic [NUM_COINS-1:0] i_input_coin;
  logic [NUM_ITEMS-1:0] i_select_item;
  logic                 i_trigger_return;
  logic [NUM_ITEMS-1:0] i_refill;
  logic [NUM_ITEMS-1:0] o_available_item;
  logic [NUM_ITEMS-1:0] o_sold_out;
  logic [NUM_ITEMS-1:0] o_output_item;
  logic [NUM_COINS-1:0] o_return_coin;
  logic                 o_coin_reject;
  logic [TOTAL_W-1:0]   o_coin_total;
  logic [1:0]           o_state;

  modport master (
    output i_input_coin, i_select_item, i_trigger_return, i_refill,
    input  o_available_item, o_sold_out, o_output_item, o_return_coin,
           o_coin_reject, o_coin_total, o_state
  );

  modport slave (
    input  i_input_coin, i_select_item, i_trigger_return, i_refill,
    output o_available_item, o_sold_out, o_output_item, o_return_coin,
           o_coin_reject, o_coin_total, o_state
  );
endinterface

// File: rtl/vend_ctrl_param.sv
// vend_ctrl_param
//   Parametrised vending-machine controller. Keeps the coin total and the
//   per-item stock, runs the purchase state machine, debounces the return
//   button, times out idle customers and pays change back one coin per cycle
//   using the largest denomination that still fits.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high
//     bus    vend_ctrl_param_if slave modport (coins, selections, return,
//            refill in; availability, sold-out, dispense, change, reject,
//            total and state out)
module vend_ctrl_param #(
  parameter int NUM_ITEMS = 4,
  parameter int NUM_COINS = 3,
  parameter int TOTAL_W   = 32,
  parameter logic [16*NUM_ITEMS-1:0] ITEM_PRICES = {16'd2000, 16'd1000, 16'd500, 16'd400},
  parameter logic [16*NUM_COINS-1:0] COIN_VALUES = {16'd1000, 16'd500, 16'd100},
  parameter int STOCK_W     = 4,
  parameter int STOCK_INIT  = 2,
  parameter int STOCK_MAX   = 15,
  parameter int WAIT_CYCLES = 100,
  parameter int RETURN_HOLD = 3
) (
  input  logic             clk,
  input  logic             reset,
  vend_ctrl_param_if.slave bus
);

  localparam int TIMER_W = $clog2(WAIT_CYCLES + 1);
  localparam int HOLD_W  = $clog2(RETURN_HOLD + 1);
  localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(WAIT_CYCLES);
  localparam logic [HOLD_W-1:0]  HOLD_MAX     = HOLD_W'(RETURN_HOLD);
  localparam logic [STOCK_W-1:0] STOCK_RST    = STOCK_W'(STOCK_INIT);
  localparam logic [STOCK_W-1:0] STOCK_FULL   = STOCK_W'(STOCK_MAX);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COIN     = 2'd1,
    S_DISPENSE = 2'd2,
    S_RETURN   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [TOTAL_W-1:0]   total_q, total_d;
  logic [STOCK_W-1:0]   stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0]   stock_d [NUM_ITEMS];
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [NUM_ITEMS-1:0] sel_q, sel_d;
  logic [NUM_ITEMS-1:0] item_q, item_d;
  logic [NUM_ITEMS-1:0] avail_q, avail_d;
  logic [NUM_ITEMS-1:0] sold_q, sold_d;
  logic [NUM_COINS-1:0] coin_q, coin_d;
  logic                 reject_q, reject_d;

  logic [TOTAL_W:0]     coin_sum, coin_wide;
  logic                 coin_any, coin_ok, coin_ovf;
  logic [TOTAL_W-1:0]   coin_add;
  logic [NUM_ITEMS-1:0] sel_low;
  logic                 sel_found, sel_valid;
  logic [TOTAL_W-1:0]   disp_price;
  logic [NUM_COINS-1:0] ret_pick;
  logic [TOTAL_W-1:0]   ret_val;
  logic                 ret_req;

  function automatic logic [TOTAL_W-1:0] price_of(input int i);
    return TOTAL_W'(ITEM_PRICES[16*i +: 16]);
  endfunction

  function automatic logic [TOTAL_W-1:0] coin_of(input int c);
    return TOTAL_W'(COIN_VALUES[16*c +: 16]);
  endfunction

  // Coin intake: sum every asserted denomination one bit wider than the
  // total so an overflowing insertion can be spotted and dropped whole.
  always_comb begin
    coin_sum = '0;
    for (int c = 0; c < NUM_COINS; c++) begin
      if (bus.i_input_coin[c]) coin_sum = coin_sum + {1'b0, coin_of(c)};
    end
    coin_wide = {1'b0, total_q} + coin_sum;
    coin_any  = |bus.i_input_coin;
    coin_ovf  = coin_wide[TOTAL_W] | coin_sum[TOTAL_W];
    coin_ok   = coin_any && !coin_ovf;
    coin_add  = coin_ok ? coin_sum[TOTAL_W-1:0] : '0;
  end

  // Selection decode, price lookup for the latched item, greedy change
  // choice and the debounced return request, all from current registers.
  // Coin values ascend with index, so the last fitting coin is the largest.
  always_comb begin
    sel_low   = '0;
    sel_found = 1'b0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (bus.i_select_item[i] && !sel_found) begin
        sel_low[i] = 1'b1;
        sel_found  = 1'b1;
      end
    end
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (sel_low[i]) sel_valid = (price_of(i) <= total_q) && (stock_q[i] != '0);
    end
    disp_price = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (sel_q[i]) disp_price = price_of(i);
    end
    ret_pick = '0;
    ret_val  = '0;
    for (int c = 0; c < NUM_COINS; c++) begin
      if (coin_of(c) <= total_q) begin
        ret_pick    = '0;
        ret_pick[c] = 1'b1;
        ret_val     = coin_of(c);
      end
    end
    ret_req = (hold_q == HOLD_MAX) && (total_q != '0);
  end

  // Next-state and next-output logic. Coins are credited in every state;
  // the state-specific arms then layer the purchase, change and timer
  // behaviour on top. Refill is applied last so it beats a dispense.
  always_comb begin
    state_d  = state_q;
    total_d  = total_q + coin_add;
    timer_d  = coin_ok ? TIMER_RELOAD : timer_q;
    sel_d    = sel_q;
    item_d   = '0;
    coin_d   = '0;
    reject_d = coin_any && coin_ovf;
    hold_d   = '0;
    for (int i = 0; i < NUM_ITEMS; i++) stock_d[i] = stock_q[i];

    if (bus.i_trigger_return) hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_W'(1);

    case (state_q)
      S_IDLE: begin
        if (coin_ok) state_d = S_COIN;
      end
      S_COIN: begin
        if (coin_ok) begin
          state_d = S_COIN;
        end else if (sel_valid) begin
          state_d = S_DISPENSE;
          sel_d   = sel_low;
        end else if (ret_req || timer_q == '0) begin
          state_d = S_RETURN;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      S_DISPENSE: begin
        total_d = total_q - disp_price + coin_add;
        item_d  = sel_q;
        timer_d = TIMER_RELOAD;
        for (int i = 0; i < NUM_ITEMS; i++) begin
          if (sel_q[i]) stock_d[i] = stock_q[i] - STOCK_W'(1);
        end
        state_d = (total_d != '0) ? S_COIN : S_IDLE;
      end
      S_RETURN: begin
        total_d = total_q - ret_val + coin_add;
        coin_d  = ret_pick;
        if (total_d == '0 || ret_pick == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (bus.i_refill[i]) stock_d[i] = STOCK_FULL;
    end

    for (int i = 0; i < NUM_ITEMS; i++) begin
      avail_d[i] = (price_of(i) <= total_q) && (stock_q[i] != '0);
      sold_d[i]  = (stock_q[i] == '0);
    end
  end

  // State and output registers with synchronous reset; a reset aborts any
  // dispense or change sequence in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      total_q  <= '0;
      timer_q  <= TIMER_RELOAD;
      hold_q   <= '0;
      sel_q    <= '0;
      item_q   <= '0;
      coin_q   <= '0;
      reject_q <= 1'b0;
      avail_q  <= '0;
      sold_q   <= (STOCK_INIT == 0) ? '1 : '0;
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_RST;
    end else begin
      state_q  <= state_d;
      total_q  <= total_d;
      timer_q  <= timer_d;
      hold_q   <= hold_d;
      sel_q    <= sel_d;
      item_q   <= item_d;
      coin_q   <= coin_d;
      reject_q <= reject_d;
      avail_q  <= avail_d;
      sold_q   <= sold_d;
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= stock_d[i];
    end
  end

  assign bus.o_state          = state_q;
  assign bus.o_coin_total     = total_q;
  assign bus.o_output_item    = item_q;
  assign bus.o_return_coin    = coin_q;
  assign bus.o_coin_reject    = reject_q;
  assign bus.o_available_item = avail_q;
  assign bus.o_sold_out       = sold_q;

endmodule
